// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the two-port ROM arbiter: widths, FSM states and
// requester port indices.
package rom_port_arbiter_pkg;

  localparam int unsigned ROM_DATA_W  = 32;
  localparam int unsigned ROM_ADDR_W  = 12;
  localparam int unsigned BURST_CNT_W = 4;

  // Requester indices; last_gnt stores one of these.
  localparam bit P_FETCH = 1'b0;
  localparam bit P_LOAD  = 1'b1;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage : rom_port_arbiter_pkg

// File: rtl/rom_port_arbiter_rsp_reg.sv
// Per-port read response register: pulses rvalid one cycle after a grant and
// captures the ROM word; rdata holds between grants.
//   clk, rst_n : clock, async active-low reset
//   i_gnt      : port granted this cycle
//   i_rdata    : combinational ROM data for the granted address
//   o_rvalid   : one-cycle response strobe
//   o_rdata    : registered read data
module rom_rsp_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_gnt,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Response capture; a reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_gnt;
      if (i_gnt) r_rdata <= i_rdata;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

endmodule : rom_rsp_reg

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between instruction
// fetch (port 0) and data load (port 1), with bounded burst locking.
//   clk, rst_n            : clock, async active-low reset
//   pX_req/addr/lock      : port X request, word address, keep-ownership hint
//   pX_gnt                : port X accepted this cycle (combinational)
//   pX_rvalid/rdata       : port X registered response, one cycle after grant
//   rom_addr / rom_data   : ROM address out, combinational ROM data in
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ROM_DATA_W,
  parameter int unsigned ADDR_WIDTH = ROM_ADDR_W,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic                  p0_lock,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic                  p1_lock,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);
  // A burst of one is just a normal grant, so locking never enters OWNx.
  localparam bit LOCK_EN = (MAX_BURST > 1);

  arb_state_e             r_state, w_state_nxt;
  logic [BURST_CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;
  logic                   r_last_gnt;
  logic [ADDR_WIDTH-1:0]  r_addr_q;
  logic                   w_gnt0, w_gnt1;
  logic                   w_prio1;
  logic                   w_arb;

  // State, burst count, round-robin pointer and held address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB;
      r_burst_cnt <= '0;
      r_last_gnt  <= P_LOAD;
      r_addr_q    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      if (p0_gnt) begin
        r_last_gnt <= P_FETCH;
        r_addr_q   <= p0_addr;
      end else if (p1_gnt) begin
        r_last_gnt <= P_LOAD;
        r_addr_q   <= p1_addr;
      end
    end
  end

  // Next state, burst count and grants. A yielding owner falls through to
  // normal arbitration in the same cycle with the peer favoured.
  always_comb begin
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    w_gnt0          = 1'b0;
    w_gnt1          = 1'b0;
    w_prio1         = (r_last_gnt == P_FETCH);
    w_arb           = 1'b1;

    case (r_state)
      OWN0: begin
        if (p0_req && p0_lock && (r_burst_cnt < BURST_LIMIT)) begin
          w_gnt0          = 1'b1;
          w_burst_cnt_nxt = r_burst_cnt + BURST_CNT_W'(1);
          w_arb           = 1'b0;
        end else begin
          w_prio1 = 1'b1;
        end
      end
      OWN1: begin
        if (p1_req && p1_lock && (r_burst_cnt < BURST_LIMIT)) begin
          w_gnt1          = 1'b1;
          w_burst_cnt_nxt = r_burst_cnt + BURST_CNT_W'(1);
          w_arb           = 1'b0;
        end else begin
          w_prio1 = 1'b0;
        end
      end
      default: ;
    endcase

    if (w_arb) begin
      if (p0_req && p1_req) begin
        w_gnt1 = w_prio1;
        w_gnt0 = !w_prio1;
      end else begin
        w_gnt0 = p0_req;
        w_gnt1 = p1_req;
      end
      if (LOCK_EN && w_gnt0 && p0_lock) begin
        w_state_nxt     = OWN0;
        w_burst_cnt_nxt = BURST_CNT_W'(1);
      end else if (LOCK_EN && w_gnt1 && p1_lock) begin
        w_state_nxt     = OWN1;
        w_burst_cnt_nxt = BURST_CNT_W'(1);
      end else begin
        w_state_nxt     = ARB;
        w_burst_cnt_nxt = '0;
      end
    end
  end

  // Grants are suppressed while reset is asserted.
  assign p0_gnt = w_gnt0 & rst_n;
  assign p1_gnt = w_gnt1 & rst_n;

  // Hold the last granted address when idle to keep the ROM bus quiet.
  assign rom_addr = p0_gnt ? p0_addr : (p1_gnt ? p1_addr : r_addr_q);

  rom_rsp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_p0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_gnt    (p0_gnt),
    .i_rdata  (rom_data),
    .o_rvalid (p0_rvalid),
    .o_rdata  (p0_rdata)
  );

  rom_rsp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_p1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_gnt    (p1_gnt),
    .i_rdata  (rom_data),
    .o_rvalid (p1_rvalid),
    .o_rdata  (p1_rdata)
  );

endmodule : rom_port_arbiter

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter. The ROM is modelled as
// A500_0000 | addr; expected responses are queued at grant time and
// compared one cycle later.
module tb_rom_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;

  typedef struct packed {
    logic          v0;
    logic          v1;
    logic [DW-1:0] d;
  } rsp_t;

  logic          clk;
  logic          rst_n;
  logic          p0_req, p0_lock, p0_gnt, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_rdata;
  logic          p1_req, p1_lock, p1_gnt, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_rdata;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  rsp_t          sb_q[$];
  logic [AW-1:0] exp_addr_q = '0;
  logic [DW-1:0] exp_rd0 = '0;
  logic [DW-1:0] exp_rd1 = '0;

  rom_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p0_addr   (p0_addr),
    .p0_lock   (p0_lock),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_addr   (p1_addr),
    .p1_lock   (p1_lock),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  assign rom_data = 32'hA500_0000 | {20'h0, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive at posedge+1, check grant/address at posedge+3,
  // then check the previous cycle's response at the next posedge+1.
  task automatic step(input logic r0, input logic [AW-1:0] a0, input logic l0,
                      input logic r1, input logic [AW-1:0] a1, input logic l1,
                      input logic eg0, input logic eg1, input string name);
    logic [AW-1:0] ea;
    rsp_t          e;
    p0_req = r0; p0_addr = a0; p0_lock = l0;
    p1_req = r1; p1_addr = a1; p1_lock = l1;
    #2;
    n_tests++;
    if ({p0_gnt, p1_gnt} !== {eg0, eg1}) begin
      n_fail++;
      $display("FAIL %s gnt: got %b%b exp %b%b", name, p0_gnt, p1_gnt, eg0, eg1);
    end
    ea = eg0 ? a0 : (eg1 ? a1 : exp_addr_q);
    n_tests++;
    if (rom_addr !== ea) begin
      n_fail++;
      $display("FAIL %s rom_addr: got %h exp %h", name, rom_addr, ea);
    end
    if (eg0 || eg1) exp_addr_q = ea;
    sb_q.push_back('{v0: eg0, v1: eg1, d: 32'hA500_0000 | {20'h0, ea}});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.v0) exp_rd0 = e.d;
    if (e.v1) exp_rd1 = e.d;
    n_tests++;
    if ({p0_rvalid, p1_rvalid} !== {e.v0, e.v1}) begin
      n_fail++;
      $display("FAIL %s rvalid: got %b%b exp %b%b", name, p0_rvalid, p1_rvalid, e.v0, e.v1);
    end
    n_tests++;
    if (p0_rdata !== exp_rd0 || p1_rdata !== exp_rd1) begin
      n_fail++;
      $display("FAIL %s rdata: got %h/%h exp %h/%h", name, p0_rdata, p1_rdata, exp_rd0, exp_rd1);
    end
  endtask

  task automatic idle(input string name);
    step(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0, name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    p0_req = 1'b1; p0_addr = 12'h055; p0_lock = 1'b1;
    p1_req = 1'b1; p1_addr = 12'h066; p1_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b0000 || rom_addr !== 12'h000) begin
      n_fail++;
      $display("FAIL reset outputs: gnt %b%b rvalid %b%b rom_addr %h exp all 0",
               p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rom_addr);
    end
    n_tests++;
    if (p0_rdata !== '0 || p1_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset rdata: got %h/%h exp 0/0", p0_rdata, p1_rdata);
    end
    p0_req = 1'b0; p1_req = 1'b0; p0_lock = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 4; i++)
      step(1'b1, 12'h001, 1'b0, 1'b1, 12'h002, 1'b0, (i % 2) == 0, (i % 2) == 1, "alternate");
  endtask

  task automatic test_single();
    step(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 1'b0, 1'b1, 1'b0, "single_p0");
    idle("single_rsp");
  endtask

  task automatic test_burst();
    // Leave last_gnt on port 1 so port 0 wins the first contended cycle.
    step(1'b0, 12'h0, 1'b0, 1'b1, 12'h200, 1'b0, 1'b0, 1'b1, "burst_pre");
    for (int i = 0; i < 4; i++)
      step(1'b1, 12'(12'h100 + i), 1'b1, 1'b1, 12'h200, 1'b0, 1'b1, 1'b0, "burst_own0");
    step(1'b1, 12'h104, 1'b1, 1'b1, 12'h200, 1'b0, 1'b0, 1'b1, "burst_yield");
    step(1'b1, 12'h104, 1'b1, 1'b0, 12'h0, 1'b0, 1'b1, 1'b0, "burst_resume");
    step(1'b1, 12'h105, 1'b0, 1'b0, 12'h0, 1'b0, 1'b1, 1'b0, "burst_unlock");
  endtask

  task automatic test_lock_drop();
    step(1'b0, 12'h0, 1'b0, 1'b1, 12'h300, 1'b1, 1'b0, 1'b1, "lockdrop_g1");
    step(1'b0, 12'h0, 1'b0, 1'b1, 12'h301, 1'b1, 1'b0, 1'b1, "lockdrop_g2");
    step(1'b0, 12'h0, 1'b0, 1'b1, 12'h302, 1'b0, 1'b0, 1'b1, "lockdrop_g3");
    step(1'b1, 12'h020, 1'b0, 1'b1, 12'h303, 1'b0, 1'b1, 1'b0, "lockdrop_p0");
    step(1'b1, 12'h021, 1'b0, 1'b1, 12'h303, 1'b0, 1'b0, 1'b1, "lockdrop_arb");
  endtask

  task automatic test_reset_mid();
    p0_req = 1'b0; p0_lock = 1'b0;
    p1_req = 1'b1; p1_addr = 12'h3AB; p1_lock = 1'b0;
    #2;
    n_tests++;
    if ({p0_gnt, p1_gnt} !== 2'b01 || rom_addr !== 12'h3AB) begin
      n_fail++;
      $display("FAIL rstmid grant: gnt %b%b rom_addr %h exp 01 3ab", p0_gnt, p1_gnt, rom_addr);
    end
    #1 rst_n = 1'b0;
    sb_q.delete();
    exp_addr_q = '0; exp_rd0 = '0; exp_rd1 = '0;
    #1;
    n_tests++;
    if ({p0_gnt, p1_gnt} !== 2'b00 || rom_addr !== 12'h000) begin
      n_fail++;
      $display("FAIL rstmid gated: gnt %b%b rom_addr %h exp 00 000", p0_gnt, p1_gnt, rom_addr);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({p0_rvalid, p1_rvalid} !== 2'b00 || p1_rdata !== '0 || p0_rdata !== '0) begin
      n_fail++;
      $display("FAIL rstmid rsp: rvalid %b%b rdata %h/%h exp 00 0/0",
               p0_rvalid, p1_rvalid, p0_rdata, p1_rdata);
    end
    rst_n = 1'b1;
    step(1'b1, 12'h040, 1'b0, 1'b1, 12'h041, 1'b0, 1'b1, 1'b0, "rstmid_first");
    step(1'b1, 12'h040, 1'b0, 1'b1, 12'h041, 1'b0, 1'b0, 1'b1, "rstmid_second");
  endtask

  task automatic test_idle_hold();
    step(1'b1, 12'h3FF, 1'b0, 1'b0, 12'h0, 1'b0, 1'b1, 1'b0, "hold_grant");
    for (int i = 0; i < 3; i++) idle("hold_idle");
  endtask

  initial begin
    rst_n = 1'b0;
    p0_req = 1'b0; p0_addr = '0; p0_lock = 1'b0;
    p1_req = 1'b0; p1_addr = '0; p1_lock = 1'b0;
    test_reset();
    test_alternate();
    test_single();
    test_burst();
    test_lock_drop();
    test_reset_mid();
    test_idle_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rom_port_arbiter
